// File: rtl/serial_subtractor_if.sv
// Start/done handshake bundle for serial_subtractor.
// The OVERFLOW signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] DIFF;
    logic             BORROW;
`ifdef SERIAL_SUB_OVF_EN
    logic             OVERFLOW;
`endif

`ifdef SERIAL_SUB_OVF_EN
    modport master (output start, A, B, input busy, done, DIFF, BORROW, OVERFLOW);
    modport slave  (input start, A, B, output busy, done, DIFF, BORROW, OVERFLOW);
`else
    modport master (output start, A, B, input busy, done, DIFF, BORROW);
    modport slave  (input start, A, B, output busy, done, DIFF, BORROW);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: DIFF = A - B mod 2^WIDTH, with BORROW = (A < B).
// Define SERIAL_SUB_OVF_EN to add the signed OVERFLOW output.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_subtractor_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [CW-1:0]    cnt_q;
    logic             bin_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb_q;
    logic             b_msb_q;
    logic             ovf_q;
`endif

    // Single full-subtractor cell shared by every bit position.
    logic             bit_d;
    logic             borrow_d;
    logic [WIDTH-1:0] res_d;

    assign bit_d    = a_q[0] ^ b_q[0] ^ bin_q;
    assign borrow_d = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bin_q);
    assign res_d    = {bit_d, res_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            bin_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        a_q     <= bus.A;
                        b_q     <= bus.B;
                        bin_q   <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb_q <= bus.A[WIDTH-1];
                        b_msb_q <= bus.B[WIDTH-1];
`endif
                    end
                end
                RUN: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    bin_q <= borrow_d;
                    res_q <= res_d;
                    cnt_q <= cnt_q + 1'b1;
                    // Final bit: publish the result; outputs stay frozen otherwise.
                    if (cnt_q == LAST) begin
                        diff_q   <= res_d;
                        borrow_q <= borrow_d;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
`ifdef SERIAL_SUB_OVF_EN
                        ovf_q    <= (a_msb_q != b_msb_q) && (bit_d != a_msb_q);
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.DIFF   = diff_q;
    assign bus.BORROW = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.OVERFLOW = ovf_q;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: driver pushes arithmetic-model results,
// a negedge monitor pops and compares on each done pulse.
module tb_serial_subtractor;
    localparam int W = 4;
    localparam int TIMEOUT = 200;

    typedef struct {
        logic [W-1:0] diff;
        logic         borrow;
        logic         ovf;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    logic [W-1:0] held_diff;
    logic         held_borrow;
    logic         held_ovf;
    logic         prev_done;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: no response within %0d cycles", name, TIMEOUT);
    endtask

    // Reference: plain modular arithmetic and signed range reasoning.
    function automatic exp_t model(input int a, input int b, input int done_cyc);
        exp_t e;
        int   m;
        int   sa;
        int   sbv;
        int   sd;
        m = 1 << W;
        e.diff   = W'((a - b + m) % m);
        e.borrow = (a < b);
        sa  = (a >= m / 2) ? a - m : a;
        sbv = (b >= m / 2) ? b - m : b;
        sd  = sa - sbv;
        e.ovf = (sd < -(m / 2)) || (sd > m / 2 - 1);
        e.cyc = done_cyc;
        return e;
    endfunction

    // Issue one operation at the first edge where the DUT is idle.
    task automatic start_op(input int a, input int b);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.busy && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        if (n >= TIMEOUT) timeout_fail("start_wait");
        bus.start = 1'b1;
        bus.A = W'(a);
        bus.B = W'(b);
        sb.push_back(model(a, b, cyc + 1 + W));
        $display("issue A=%0d B=%0d", a, b);
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // Monitor: compare on done, otherwise confirm the result registers hold.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_done   = 1'b0;
            held_diff   = '0;
            held_borrow = 1'b0;
            held_ovf    = 1'b0;
        end else begin
            if (bus.done) begin
                exp_t e;
                chk("done_single_cycle", int'(prev_done), 0);
                chk("busy_at_done", int'(bus.busy), 0);
                if (sb.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    $display("done DIFF=%0d BORROW=%0d exp DIFF=%0d BORROW=%0d at cycle %0d",
                             bus.DIFF, bus.BORROW, e.diff, e.borrow, cyc);
                    chk("diff", int'(bus.DIFF), int'(e.diff));
                    chk("borrow", int'(bus.BORROW), int'(e.borrow));
                    chk("latency", cyc, e.cyc);
`ifdef SERIAL_SUB_OVF_EN
                    chk("overflow", int'(bus.OVERFLOW), int'(e.ovf));
`endif
                    held_diff   = e.diff;
                    held_borrow = e.borrow;
                    held_ovf    = e.ovf;
                end
            end else begin
                chk("diff_hold", int'(bus.DIFF), int'(held_diff));
                chk("borrow_hold", int'(bus.BORROW), int'(held_borrow));
`ifdef SERIAL_SUB_OVF_EN
                chk("overflow_hold", int'(bus.OVERFLOW), int'(held_ovf));
`endif
            end
            prev_done = bus.done;
        end
    end

    initial begin
        int n;
        bus.start = 1'b0;
        bus.A = '0;
        bus.B = '0;

        // Asynchronous reset before any clock edge.
        #1 rst_n = 1'b0;
        #2;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_diff", int'(bus.DIFF), 0);
        chk("rst_borrow", int'(bus.BORROW), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("idle_busy", int'(bus.busy), 0);
            chk("idle_done", int'(bus.done), 0);
        end

        // Directed cases.
        start_op(9, 3);
        start_op(3, 9);
        start_op(8, 1);
        start_op(15, 15);
        start_op(0, 15);
        start_op(0, 0);

        // Start during RUN is ignored; start held through done is accepted.
        start_op(5, 2);
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        bus.A = W'(1);
        bus.B = W'(1);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.A = W'(12);
        bus.B = W'(4);
        n = 0;
        while (!bus.done && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        if (n >= TIMEOUT) timeout_fail("b2b_wait");
        sb.push_back(model(12, 4, cyc + 1 + W));
        $display("issue A=12 B=4 (held start)");
        @(posedge clk);
        #1 bus.start = 1'b0;

        // Reset mid-operation.
        start_op(7, 2);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        sb.delete();
        chk("midrst_busy", int'(bus.busy), 0);
        chk("midrst_done", int'(bus.done), 0);
        chk("midrst_diff", int'(bus.DIFF), 0);
        chk("midrst_borrow", int'(bus.BORROW), 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        start_op(7, 2);

        // Randomized operations with random idle gaps.
        for (int i = 0; i < 40; i++) begin
            start_op(int'($urandom_range(0, (1 << W) - 1)), int'($urandom_range(0, (1 << W) - 1)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        n = 0;
        while (sb.size() != 0 && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb.size(), 0);
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
